// File: rtl/seq_window_mapper.sv
// seq_window_mapper: generates K strided addresses (base + j*stride) mod SIZE,
//   then builds the inverse map (address -> lowest generating slot, hit flag)
//   by scanning LANES addresses per cycle.
// Latency: NCH = SIZE/LANES cycles from accept to done_valid.
// Backpressure: a single request in flight; start_ready is low outside IDLE and
//   results hold in DONE until done_ready.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_valid/start_ready   request handshake carrying base, stride
//   nums                      registered generated addresses, slot j at [j*AW +: AW]
//   map_idx, map_hit          inverse map, address v at [v*IW +: IW] / bit v
//   done_valid/done_ready     result handshake
//   busy                      high while SCAN or DONE
module seq_window_mapper #(
  parameter int SIZE  = 16,
  parameter int K     = 8,
  parameter int LANES = 4,
  localparam int AW   = $clog2(SIZE),
  localparam int IW   = $clog2(K),
  localparam int NCH  = SIZE / LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AW-1:0]        base,
  input  logic [AW-1:0]        stride,
  output logic [AW*K-1:0]      nums,
  output logic [SIZE*IW-1:0]   map_idx,
  output logic [SIZE-1:0]      map_hit,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [AW*K-1:0]     nums_q, nums_d;
  logic [SIZE*IW-1:0]  idx_q, idx_d;
  logic [SIZE-1:0]     hit_q, hit_d;
  logic [CW-1:0]       chunk_q, chunk_d;

  // Per-lane scratch for the comparator tree.
  logic [AW-1:0]       lane_addr;
  logic                lane_hit;
  logic [IW-1:0]       lane_idx;

  always_comb begin
    state_d   = state_q;
    nums_d    = nums_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    chunk_d   = chunk_q;
    lane_addr = '0;
    lane_hit  = 1'b0;
    lane_idx  = '0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          // Truncation to AW bits gives the mod-SIZE wrap for free.
          for (int j = 0; j < K; j++) begin
            nums_d[j*AW +: AW] = base + AW'(j) * stride;
          end
          idx_d   = '0;
          hit_d   = '0;
          chunk_d = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        for (int l = 0; l < LANES; l++) begin
          lane_addr = AW'(int'(chunk_q) * LANES + l);
          lane_hit  = 1'b0;
          lane_idx  = '0;
          // Walk slots high to low so the lowest matching slot is the one left standing.
          for (int j = K - 1; j >= 0; j--) begin
            if (nums_q[j*AW +: AW] == lane_addr) begin
              lane_hit = 1'b1;
              lane_idx = IW'(j);
            end
          end
          hit_d[lane_addr]                = lane_hit;
          idx_d[int'(lane_addr)*IW +: IW] = lane_idx;
        end
        if (chunk_q == CW'(NCH - 1)) begin
          chunk_d = '0;
          state_d = DONE;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end

      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nums_q  <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      nums_q  <= nums_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      chunk_q <= chunk_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done_valid  = (state_q == DONE);
  assign nums        = nums_q;
  assign map_idx     = idx_q;
  assign map_hit     = hit_q;

endmodule

// File: tb/tb_seq_window_mapper.sv
module tb_seq_window_mapper;

  localparam int SIZE  = 16;
  localparam int K     = 8;
  localparam int LANES = 4;
  localparam int AW    = $clog2(SIZE);
  localparam int IW    = $clog2(K);
  localparam int NCH   = SIZE / LANES;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_valid;
  logic                start_ready;
  logic [AW-1:0]       base;
  logic [AW-1:0]       stride;
  logic [AW*K-1:0]     nums;
  logic [SIZE*IW-1:0]  map_idx;
  logic [SIZE-1:0]     map_hit;
  logic                done_valid;
  logic                done_ready;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference results for the current request.
  logic [AW*K-1:0]     exp_nums;
  logic [SIZE*IW-1:0]  exp_idx;
  logic [SIZE-1:0]     exp_hit;

  seq_window_mapper #(.SIZE(SIZE), .K(K), .LANES(LANES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .base        (base),
    .stride      (stride),
    .nums        (nums),
    .map_idx     (map_idx),
    .map_hit     (map_hit),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inverse map from first principles: walk slots in order, first writer of an address keeps it.
  task automatic model(input int b, input int s);
    int n;
    exp_nums = '0;
    exp_idx  = '0;
    exp_hit  = '0;
    for (int j = 0; j < K; j++) begin
      n = (b + j * s) % SIZE;
      exp_nums[j*AW +: AW] = AW'(n);
      if (!exp_hit[n]) begin
        exp_hit[n]          = 1'b1;
        exp_idx[n*IW +: IW] = IW'(j);
      end
    end
  endtask

  // Issue one request and wait for done_valid; lat = edges from accept to done (999 on timeout).
  task automatic run_req(input int b, input int s, output int lat);
    int guard;
    guard = 0;
    while (!start_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    start_valid = 1'b1;
    base        = AW'(b);
    stride      = AW'(s);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!done_valid) lat = 999;
  endtask

  task automatic release_done();
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    start_valid = 1'b1;
    base        = 4'd3;
    stride      = 4'd1;
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    start_valid = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, want 1 0 0", start_ready, busy, done_valid);
    end
    n_checks++;
    if (nums !== '0 || map_hit !== '0 || map_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got nums=%h hit=%h idx=%h, want all 0", nums, map_hit, map_idx);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || nums !== '0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got busy=%b nums=%h, want 0 0", busy, nums);
    end
  endtask

  // Directed request: checks latency, nums/map vs model, and a hand-derived hit mask.
  task automatic test_directed(input string name, input int b, input int s, input logic [SIZE-1:0] hit_const);
    int lat;
    model(b, s);
    run_req(b, s, lat);
    n_checks++;
    if (lat !== NCH) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, NCH);
    end
    n_checks++;
    if (nums !== exp_nums) begin
      n_fail++;
      $display("FAIL %s_nums: got %h, want %h", name, nums, exp_nums);
    end
    n_checks++;
    if (map_hit !== hit_const || map_hit !== exp_hit) begin
      n_fail++;
      $display("FAIL %s_hit: got %h, want %h", name, map_hit, hit_const);
    end
    n_checks++;
    if (map_idx !== exp_idx) begin
      n_fail++;
      $display("FAIL %s_idx: got %h, want %h", name, map_idx, exp_idx);
    end
    release_done();
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: got ready=%b busy=%b, want 1 0", name, start_ready, busy);
    end
  endtask

  // Spot checks of individual map entries taken straight from hand-computed values.
  task automatic test_spot_entries();
    int lat;
    run_req(13, 1, lat);
    n_checks++;
    if (map_idx[13*IW +: IW] !== 3'd0 || map_idx[15*IW +: IW] !== 3'd2 ||
        map_idx[0 +: IW] !== 3'd3 || map_idx[4*IW +: IW] !== 3'd7) begin
      n_fail++;
      $display("FAIL wrap_entries: got idx=%h, want [13]=0 [15]=2 [0]=3 [4]=7", map_idx);
    end
    release_done();
    run_req(2, 4, lat);
    n_checks++;
    if (map_idx[2*IW +: IW] !== 3'd0 || map_idx[6*IW +: IW] !== 3'd1 ||
        map_idx[10*IW +: IW] !== 3'd2 || map_idx[14*IW +: IW] !== 3'd3) begin
      n_fail++;
      $display("FAIL collide_entries: got idx=%h, want [2]=0 [6]=1 [10]=2 [14]=3", map_idx);
    end
    release_done();
  endtask

  task automatic test_random();
    int lat, b, s;
    for (int i = 0; i < 24; i++) begin
      b = $urandom_range(0, SIZE - 1);
      s = $urandom_range(0, SIZE - 1);
      model(b, s);
      run_req(b, s, lat);
      n_checks++;
      if (lat !== NCH || nums !== exp_nums || map_hit !== exp_hit || map_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL random b=%0d s=%0d: got lat=%0d nums=%h hit=%h idx=%h, want lat=%0d nums=%h hit=%h idx=%h",
                 b, s, lat, nums, map_hit, map_idx, NCH, exp_nums, exp_hit, exp_idx);
      end
      release_done();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int lst [K] = '{5, 8, 11, 14, 1, 4, 7, 10};
    logic [AW*K-1:0] want_nums;
    model(7, 5);
    run_req(7, 5, lat);
    for (int c = 0; c < 5; c++) begin
      start_valid = c[0];
      base        = 4'd0;
      stride      = 4'd1;
      @(negedge clk);
      n_checks++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || nums !== exp_nums ||
          map_hit !== exp_hit || map_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL backpressure_hold c=%0d: got done=%b ready=%b nums=%h hit=%h, want 1 0 %h %h",
                 c, done_valid, start_ready, nums, map_hit, exp_nums, exp_hit);
      end
    end
    start_valid = 1'b0;
    release_done();
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got ready=%b busy=%b done=%b, want 1 0 0", start_ready, busy, done_valid);
    end
    for (int j = 0; j < K; j++) want_nums[j*AW +: AW] = AW'(lst[j]);
    model(5, 3);
    run_req(5, 3, lat);
    n_checks++;
    if (lat !== NCH || nums !== want_nums || map_hit !== exp_hit || map_idx !== exp_idx) begin
      n_fail++;
      $display("FAIL backpressure_next: got lat=%0d nums=%h hit=%h, want %0d %h %h", lat, nums, map_hit, NCH, want_nums, exp_hit);
    end
    release_done();
  endtask

  task automatic test_reset_midscan();
    int lat;
    bit saw_done;
    start_valid = 1'b1;
    base        = 4'd4;
    stride      = 4'd3;
    @(negedge clk);
    start_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_busy: got busy=%b ready=%b, want 1 0", busy, start_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 ||
        nums !== '0 || map_hit !== '0 || map_idx !== '0) begin
      n_fail++;
      $display("FAIL midscan_reset: got ready=%b busy=%b done=%b nums=%h hit=%h idx=%h, want 1 0 0 and zero data",
               start_ready, busy, done_valid, nums, map_hit, map_idx);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_valid) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_no_done: got done_valid seen=%b, want 0", saw_done);
    end
    model(11, 7);
    run_req(11, 7, lat);
    n_checks++;
    if (lat !== NCH || nums !== exp_nums || map_hit !== exp_hit || map_idx !== exp_idx) begin
      n_fail++;
      $display("FAIL midscan_next: got lat=%0d nums=%h hit=%h idx=%h, want %0d %h %h %h",
               lat, nums, map_hit, map_idx, NCH, exp_nums, exp_hit, exp_idx);
    end
    release_done();
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    base        = '0;
    stride      = '0;
    @(negedge clk);
    test_reset();
    test_directed("consec", 0, 1, 16'h00FF);
    test_directed("wrap",   13, 1, 16'hE01F);
    test_directed("collide", 2, 4, 16'h4444);
    test_directed("stride0", 9, 0, 16'h0200);
    test_spot_entries();
    test_random();
    test_backpressure();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_window_mapper.md
# seq_window_mapper

Sequential, handshaked successor to the combinational window-to-slot mapping path. The block accepts a base address and a stride and generates K addresses, `(base + j*stride) mod SIZE` for j = 0..K-1. It then scans the SIZE-entry address space LANES entries per cycle, building an inverse map: for each address, the generator slot index that produced it, plus a hit flag. It sits between the request decoder and the array-selection stage, and replaces the single-cycle wide comparator array with a time-multiplexed one.

## Interface
- SIZE, 16, address-space size; power of two, ≥ 2; AW = $clog2(SIZE)
- K, 8, generated numbers per request; 2 ≤ K ≤ SIZE; IW = $clog2(K)
- LANES, 4, entries evaluated per scan cycle; must divide SIZE; NCH = SIZE/LANES

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request present
- start_ready  out  1  block can accept a request
- base  in  AW  first generated address
- stride  in  AW  address increment; 1 reproduces the consecutive-window mode
- nums  out  AW*K  registered generated addresses; slot j at bits [j*AW +: AW]
- map_idx  out  SIZE*IW  per-address slot index; address v at bits [v*IW +: IW]
- map_hit  out  SIZE  per-address hit flag; bit v set when some slot generated v
- done_valid  out  1  nums, map_idx and map_hit are complete and stable
- done_ready  in  1  consumer takes the result
- busy  out  1  high in SCAN and DONE

## Operation
- States: IDLE, SCAN, DONE.
- start_ready = (state == IDLE). busy = (state != IDLE). Both are decoded combinationally from the registered state.
- **Accept** (IDLE, start_valid & start_ready):
  - register nums[j] = (base + j*stride) mod SIZE;
  - clear map_idx and map_hit to 0;
  - chunk counter = 0;
  - go to SCAN.
- **Arithmetic**: all address math is truncated to AW bits. Wrap-around is implicit because SIZE is a power of two.
- **SCAN**: each cycle, evaluate entries v = c*LANES .. c*LANES+LANES-1 against the registered nums.
  - map_hit[v] = OR over j of (nums[j] == v).
  - map_idx[v] = lowest j with nums[j] == v. The lowest index wins on collisions, which occur when stride shares factors with SIZE or stride = 0.
  - map_idx[v] = 0 when there is no hit.
  - Increment c. After the chunk c = NCH-1 is written, go to DONE.
- **DONE**: done_valid = 1.
  - All outputs hold stable while done_ready = 0.
  - On done_ready = 1, go to IDLE.
- start_valid is ignored outside IDLE; no request is queued.
- Outputs keep the last result while IDLE, until the next accept clears map_*.
- **Reset** (any state, including mid-SCAN and DONE):
  - next edge: state IDLE;
  - nums, map_idx, map_hit, counter = 0;
  - done_valid = 0;
  - the in-flight request is discarded.
  - start_valid is ignored while rst = 1.

## Timing
- After the reset edge: start_ready = 1, busy = 0, done_valid = 0, all data outputs 0.
- Accept edge E0. Chunk c is written at edge E(c+1). State becomes DONE at edge E(NCH).
- done_valid is first high in the cycle after E(NCH): latency NCH cycles from acceptance (4 with defaults).
- Handshake completes on the edge where done_valid & done_ready. start_ready is high the following cycle.
- Minimum request-to-request spacing is NCH + 2 cycles (one DONE cycle plus one IDLE cycle).
- Partial map_* contents are visible during SCAN but are defined as invalid until done_valid.
- No combinational path from any input to any output; all outputs are registered or state-decoded.

## Test plan
Defaults throughout: SIZE=16, K=8, LANES=4.

1. Reset: hold rst 2 cycles with start_valid=1 -> after release start_ready=1, busy=0, done_valid=0, nums=0, map_hit=0; no request accepted during rst.
2. base=0, stride=1 -> done_valid 4 cycles after accept; nums = 0..7; map_hit = 16'h00FF; map_idx[v] = v for v = 0..7, and 0 for v = 8..15.
3. Wrap: base=13, stride=1 -> nums = 13,14,15,0,1,2,3,4; map_idx[13]=0, [15]=2, [0]=3, [4]=7; map_hit = 16'hE01F.
4. Collisions: base=2, stride=4 -> nums = 2,6,10,14,2,6,10,14; map_hit = 16'h4444; map_idx[2]=0, [6]=1, [10]=2, [14]=3.
5. Collisions, stride 0: base=9, stride=0 -> map_hit = 16'h0200, map_idx[9]=0.
6. Backpressure: hold done_ready=0 for 5 cycles after done_valid while pulsing start_valid -> outputs stable, start_ready=0, no accept. Raise done_ready -> IDLE next cycle; a new request (base=5, stride=3) is then accepted and completes with nums = 5,8,11,14,1,4,7,10.
7. Reset mid-scan: assert rst for 1 cycle at the second SCAN cycle -> next cycle IDLE, all outputs 0, done_valid never rises for the aborted request; the next request completes normally.
